ef_uart_tx_arbiter: RTL and testbench



---
 rtl/ef_uart_tx_arbiter.sv | 175 +++++++++++++++++
 tb/tb_ef_uart_tx_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ef_uart_tx_arbiter.sv
// rtl/ef_uart_tx_arbiter.sv - packet-locked round-robin arbiter for the EF_UART TX FIFO write port
// Optional stalled-grant timeout: define EF_UART_ARB_TIMEOUT_EN.
module ef_uart_tx_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DW      = 9,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*DW-1:0]      req_data,
  input  logic [N_REQ-1:0]         req_last,
  output logic [N_REQ-1:0]         req_ready,
  input  logic                     uart_en,
  input  logic                     tx_fifo_full,
  output logic                     tx_fifo_wr,
  output logic [DW-1:0]            tx_fifo_wdata,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     busy,
  output logic                     timeout_err,
  input  logic                     timeout_clr
);

  localparam int GW = $clog2(N_REQ);

  typedef enum logic {S_IDLE, S_XFER} state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] last_grant_q, last_grant_d;
  logic          busy_q, busy_d;
  logic [GW-1:0] pick;
  logic          sel_valid, sel_last, can_move, beat_acc;
  logic [DW-1:0] sel_data;

`ifdef EF_UART_ARB_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d, cnt_inc;
  logic        err_q, err_d;
  assign cnt_inc = cnt_q + 16'd1;
`endif

  // Round-robin pick: lowest valid index above last_grant, else lowest valid index overall
  always_comb begin
    logic [GW-1:0] pick_hi, pick_lo;
    logic          found_hi;
    pick_hi  = '0;
    pick_lo  = '0;
    found_hi = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        pick_lo = GW'(i);
        if (GW'(i) > last_grant_q) begin
          pick_hi  = GW'(i);
          found_hi = 1'b1;
        end
      end
    end
    pick = found_hi ? pick_hi : pick_lo;
  end

  // Route the granted requester's beat onto the FIFO side
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q == GW'(i)) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[i*DW +: DW];
      end
    end
  end

  assign can_move = (state_q == S_XFER) && uart_en && !tx_fifo_full;
  assign beat_acc = can_move && sel_valid;

  // Only the locked requester ever sees ready, and only while the FIFO can take a beat
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (can_move && (grant_q == GW'(i))) req_ready[i] = 1'b1;
    end
  end

  assign tx_fifo_wr    = beat_acc;
  assign tx_fifo_wdata = sel_data;
  assign grant_id      = grant_q;
  assign busy          = busy_q;

  // Next-state: lock on a packet in IDLE, release on the accepted last beat (or stall timeout)
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    busy_d       = busy_q;
`ifdef EF_UART_ARB_TIMEOUT_EN
    cnt_d = cnt_q;
    err_d = err_q & ~timeout_clr;
`endif
    case (state_q)
      S_IDLE: begin
        if (uart_en && (|req_valid)) begin
          state_d      = S_XFER;
          grant_d      = pick;
          last_grant_d = pick;
          busy_d       = 1'b1;
`ifdef EF_UART_ARB_TIMEOUT_EN
          cnt_d = '0;
`endif
        end
      end
      S_XFER: begin
        if (beat_acc && sel_last) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
`ifdef EF_UART_ARB_TIMEOUT_EN
        // Only an absent beat counts as idle; back-pressure with a beat pending does not
        if (beat_acc) begin
          cnt_d = '0;
        end else if (!sel_valid) begin
          if (cnt_inc == 16'(TIMEOUT)) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            err_d   = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; last_grant resets to N_REQ-1 so requester 0 wins first
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(N_REQ - 1);
      busy_q       <= 1'b0;
`ifdef EF_UART_ARB_TIMEOUT_EN
      cnt_q        <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      busy_q       <= busy_d;
`ifdef EF_UART_ARB_TIMEOUT_EN
      cnt_q        <= cnt_d;
      err_q        <= err_d;
`endif
    end
  end

`ifdef EF_UART_ARB_TIMEOUT_EN
  assign timeout_err = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = timeout_clr & (TIMEOUT != 0);
  assign timeout_err    = 1'b0;
`endif

  // A held-off requester must present the same beat until it is taken
  for (genvar i = 0; i < N_REQ; i++) begin : g_hold_chk
    a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
      (req_valid[i] && !req_ready[i]) |=> (req_valid[i] && $stable(req_data[i*DW +: DW])));
  end

endmodule

// File: tb/tb_ef_uart_tx_arbiter.sv
// tb/tb_ef_uart_tx_arbiter.sv - scoreboard and table-driven bench for ef_uart_tx_arbiter
module tb_ef_uart_tx_arbiter;

  localparam int N = 4;
  localparam int W = 9;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid, req_last, req_ready;
  logic [N*W-1:0] req_data;
  logic           uart_en, tx_fifo_full, tx_fifo_wr;
  logic [W-1:0]   tx_fifo_wdata;
  logic [1:0]     grant_id;
  logic           busy, timeout_err, timeout_clr;

  always #5 clk = ~clk;

  ef_uart_tx_arbiter #(.N_REQ(N), .DW(W), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .uart_en(uart_en), .tx_fifo_full(tx_fifo_full),
    .tx_fifo_wr(tx_fifo_wr), .tx_fifo_wdata(tx_fifo_wdata),
    .grant_id(grant_id), .busy(busy),
    .timeout_err(timeout_err), .timeout_clr(timeout_clr)
  );

  typedef struct packed {
    logic [1:0] id;
    logic [8:0] data;
  } exp_t;

  typedef struct packed {
    logic en;
    logic full;
    logic wr;
    logic busy;
    logic rdy0;
  } vec_t;

  exp_t       exp_q[$];
  logic [9:0] rq[N][$];
  int         wr_cyc[$];
  vec_t       bp_tab[16];
  int         cyc;
  int         n_vec;
  int         n_miss;
  logic [N-1:0] acc, hold_mask;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (rq[i].size() > 0) begin
        req_valid[i]       = 1'b1;
        req_last[i]        = rq[i][0][9];
        req_data[i*W +: W] = rq[i][0][8:0];
      end else begin
        req_valid[i]       = 1'b0;
        req_last[i]        = 1'b0;
        req_data[i*W +: W] = '0;
      end
    end
  endtask

  task automatic push(int r, logic [8:0] d, logic l, logic expect_wr);
    exp_t e;
    rq[r].push_back({l, d});
    if (expect_wr) begin
      e.id   = 2'(r);
      e.data = d;
      exp_q.push_back(e);
    end
  endtask

  task automatic sample();
    exp_t e;
    @(negedge clk);
    if (tx_fifo_wr) begin
      wr_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_wr: got write of 0x%0h, expected no write", tx_fifo_wdata);
      end else begin
        e = exp_q.pop_front();
        check("wr_data", 32'(tx_fifo_wdata), 32'(e.data));
        check("wr_grant", 32'(grant_id), 32'(e.id));
      end
    end
    if (!uart_en || tx_fifo_full) check("stall_no_wr", 32'(tx_fifo_wr), 0);
    for (int i = 0; i < N; i++) begin
      if (hold_mask[i]) check("held_off_ready", 32'(req_ready[i]), 0);
    end
    acc = req_valid & req_ready;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) void'(rq[i].pop_front());
    end
    drive();
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  task automatic drain(int bound, string name);
    for (int c = 0; c < bound && exp_q.size() > 0; c++) step();
    check({name, "_drain"}, 32'(exp_q.size()), 0);
  endtask

  task automatic check_reset_state(string name);
    sample();
    check({name, "_busy"}, 32'(busy), 0);
    check({name, "_grant"}, 32'(grant_id), 0);
    check({name, "_terr"}, 32'(timeout_err), 0);
    check({name, "_ready"}, 32'(req_ready), 0);
    check({name, "_wr"}, 32'(tx_fifo_wr), 0);
    advance();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) rq[i].delete();
    exp_q.delete();
    drive();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int c0;
    rst_n = 1'b0; uart_en = 1'b1; tx_fifo_full = 1'b0; timeout_clr = 1'b0;
    req_valid = '0; req_last = '0; req_data = '0;
    hold_mask = '0; acc = '0; cyc = 0; n_vec = 0; n_miss = 0;

    // en full wr busy rdy0 per cycle: 5 cycles FIFO full, then 3 cycles UART off
    bp_tab[0] = 5'b10000;
    bp_tab[1] = 5'b10111;
    for (int k = 2; k <= 6; k++) bp_tab[k] = 5'b11010;
    for (int k = 7; k <= 9; k++) bp_tab[k] = 5'b00010;
    for (int k = 10; k <= 14; k++) bp_tab[k] = 5'b10111;
    bp_tab[15] = 5'b10000;

    drive();
    step();
    step();
    rst_n = 1'b1;
    check_reset_state("por");

    // Reset priority: req0 before req2, one bubble between
    wr_cyc.delete();
    push(0, 9'h41, 1'b1, 1'b1);
    push(2, 9'h42, 1'b1, 1'b1);
    drive();
    c0 = cyc;
    drain(20, "rst_prio");
    check("rst_prio_nwr", 32'(wr_cyc.size()), 2);
    if (wr_cyc.size() == 2) begin
      check("first_wr_latency", 32'(wr_cyc[0] - c0), 1);
      check("pkt_bubble", 32'(wr_cyc[1] - wr_cyc[0]), 2);
    end

    // Packet lock: move pointer to 0, then req1 4-beat packet beats req0
    push(0, 9'h05, 1'b1, 1'b1);
    drive();
    drain(10, "ptr_to0");
    wr_cyc.delete();
    for (int b = 0; b < 4; b++) push(1, 9'(9'h10 + b), (b == 3), 1'b1);
    push(0, 9'h20, 1'b1, 1'b1);
    drive();
    hold_mask = 4'b0001;
    for (int c = 0; c < 30 && exp_q.size() > 1; c++) step();
    hold_mask = '0;
    drain(10, "lock");
    check("lock_nwr", 32'(wr_cyc.size()), 5);
    if (wr_cyc.size() >= 4) check("lock_consecutive", 32'(wr_cyc[3] - wr_cyc[0]), 3);

    // Round-robin fairness: 32 two-beat packets, order 0,1,2,3 repeating
    do_reset();
    wr_cyc.delete();
    for (int p = 0; p < 8; p++)
      for (int i = 0; i < N; i++)
        for (int b = 0; b < 2; b++)
          push(i, 9'(i * 64 + p * 2 + b), (b == 1), 1'b1);
    drive();
    drain(200, "rr");
    check("rr_nwr", 32'(wr_cyc.size()), 64);
    if (wr_cyc.size() == 64) check("rr_span", 32'(wr_cyc[63] - wr_cyc[0]), 94);

    // Back-pressure: table of per-cycle controls and expectations
    for (int b = 0; b < 6; b++) push(0, 9'(9'h100 + b), (b == 5), 1'b1);
    drive();
    for (int k = 0; k < 16; k++) begin
      uart_en      = bp_tab[k].en;
      tx_fifo_full = bp_tab[k].full;
      sample();
      check("bp_wr", 32'(tx_fifo_wr), 32'(bp_tab[k].wr));
      check("bp_busy", 32'(busy), 32'(bp_tab[k].busy));
      check("bp_ready0", 32'(req_ready[0]), 32'(bp_tab[k].rdy0));
      advance();
    end
    uart_en = 1'b1;
    tx_fifo_full = 1'b0;
    check("bp_drain", 32'(exp_q.size()), 0);

    // Reset after 2 of 4 beats; next arbitration restarts at requester 0
    for (int b = 0; b < 4; b++) push(1, 9'(9'h30 + b), (b == 3), (b < 2));
    drive();
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) step();
    check("mid_pkt_partial", 32'(exp_q.size()), 0);
    do_reset();
    check_reset_state("mid_rst");
    push(0, 9'h50, 1'b1, 1'b1);
    push(3, 9'h53, 1'b1, 1'b1);
    drive();
    drain(20, "post_rst_prio");

    // Timeout: req3 sends an open packet then goes quiet
    push(3, 9'h77, 1'b0, 1'b1);
    drive();
    drain(10, "to_first");
    for (int k = 1; k <= 8; k++) begin
      sample();
      check("to_lock_held", 32'(busy), 1);
      advance();
    end
    sample();
`ifdef EF_UART_ARB_TIMEOUT_EN
    check("to_busy_drop", 32'(busy), 0);
    check("to_err_set", 32'(timeout_err), 1);
    advance();
    sample();
    check("to_err_sticky", 32'(timeout_err), 1);
    advance();
    timeout_clr = 1'b1;
    step();
    timeout_clr = 1'b0;
    sample();
    check("to_err_clr", 32'(timeout_err), 0);
    check("to_idle", 32'(busy), 0);
    advance();
`else
    check("nto_busy_held", 32'(busy), 1);
    check("nto_err_zero", 32'(timeout_err), 0);
    advance();
    push(3, 9'h78, 1'b1, 1'b1);
    drive();
    drain(10, "nto_close");
    sample();
    check("nto_released", 32'(busy), 0);
    advance();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
